// File: rtl/jeff_mux_pkg.sv
// Shared definitions for the jeff_74x157 feeder: scheduler state encoding and select constants.
package jeff_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/jeff_sync_fifo.sv
// Small synchronous FIFO whose head word is always visible on dout (no read latency).
module jeff_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];
    // A full FIFO refuses the push even if it pops on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: rtl/jeff_mux_scheduler.sv
// Round-robin feeder for the jeff_74x157 mux: two channel FIFOs plus a registered scheduler.
// Optional grant counters are enabled with JEFF_MUX_SCHEDULER_STATS_EN.
module jeff_mux_scheduler
    import jeff_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    output logic             mux_s,
    output logic             mux_en,
    input  logic             y_ready
`ifdef JEFF_MUX_SCHEDULER_STATS_EN
    ,
    output logic [15:0]      a_grants,
    output logic [15:0]      b_grants
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_full, a_empty, b_full, b_empty;
    logic [CW-1:0] a_count, b_count;
    logic          a_push, b_push, a_pop, b_pop;
    logic          a_left, b_left;
    logic          idle_pick_b;

    state_t        state_reg;
    logic          sel_reg;
    logic          en_reg;
    logic          last_valid_reg;
    logic          last_b_reg;

    assign a_ready = !rst && !a_full;
    assign b_ready = !rst && !b_full;
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;
    assign a_pop   = en_reg && y_ready && (sel_reg == SEL_A);
    assign b_pop   = en_reg && y_ready && (sel_reg == SEL_B);
    assign mux_s   = sel_reg;
    assign mux_en  = en_reg;

    jeff_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .srst(rst), .din(a_in), .push(a_push), .pop(a_pop),
        .dout(mux_a), .full(a_full), .empty(a_empty), .count(a_count)
    );

    jeff_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .srst(rst), .din(b_in), .push(b_push), .pop(b_pop),
        .dout(mux_b), .full(b_full), .empty(b_empty), .count(b_count)
    );

    // Channel still holds a word after this edge's pop (a same-edge push refills it).
    assign a_left = (a_count > CW'(1)) || a_push;
    assign b_left = (b_count > CW'(1)) || b_push;

    // From IDLE: with both pending, the channel not served last wins; otherwise whoever has data.
    assign idle_pick_b = b_empty ? 1'b0 :
                         a_empty ? 1'b1 :
                         (last_valid_reg && !last_b_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sel_reg        <= SEL_A;
            en_reg         <= 1'b0;
            last_valid_reg <= 1'b0;
            last_b_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!a_empty || !b_empty) begin
                        state_reg <= idle_pick_b ? SERVE_B : SERVE_A;
                        sel_reg   <= idle_pick_b ? SEL_B : SEL_A;
                        en_reg    <= 1'b1;
                    end
                end
                SERVE_A: begin
                    if (a_pop) begin
                        last_valid_reg <= 1'b1;
                        last_b_reg     <= 1'b0;
                        if (!b_empty) begin
                            state_reg <= SERVE_B;
                            sel_reg   <= SEL_B;
                        end else if (!a_left) begin
                            state_reg <= IDLE;
                            en_reg    <= 1'b0;
                        end
                    end
                end
                SERVE_B: begin
                    if (b_pop) begin
                        last_valid_reg <= 1'b1;
                        last_b_reg     <= 1'b1;
                        if (!a_empty) begin
                            state_reg <= SERVE_A;
                            sel_reg   <= SEL_A;
                        end else if (!b_left) begin
                            state_reg <= IDLE;
                            en_reg    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    en_reg    <= 1'b0;
                end
            endcase
        end
    end

`ifdef JEFF_MUX_SCHEDULER_STATS_EN
    logic [15:0] a_grants_reg;
    logic [15:0] b_grants_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_grants_reg <= '0;
            b_grants_reg <= '0;
        end else begin
            if (a_pop && (a_grants_reg != 16'hFFFF)) begin
                a_grants_reg <= a_grants_reg + 16'd1;
            end
            if (b_pop && (b_grants_reg != 16'hFFFF)) begin
                b_grants_reg <= b_grants_reg + 16'd1;
            end
        end
    end

    assign a_grants = a_grants_reg;
    assign b_grants = b_grants_reg;
`endif

endmodule

// File: tb/tb_jeff_mux_scheduler.sv
// Directed bench: scheduler driving a behavioural 74x157 output, checked with immediate assertions.
module tb_jeff_mux_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a_in, b_in;
    logic       a_valid, b_valid, y_ready;
    logic       a_ready, b_ready;
    logic [3:0] mux_a, mux_b;
    logic       mux_s, mux_en;
    logic [3:0] y;
`ifdef JEFF_MUX_SCHEDULER_STATS_EN
    logic [15:0] a_grants, b_grants;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp3 [8];

    always #5 clk = ~clk;

    jeff_mux_scheduler #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid(a_valid), .a_ready(a_ready),
        .b_in(b_in), .b_valid(b_valid), .b_ready(b_ready),
        .mux_a(mux_a), .mux_b(mux_b), .mux_s(mux_s), .mux_en(mux_en),
        .y_ready(y_ready)
`ifdef JEFF_MUX_SCHEDULER_STATS_EN
        , .a_grants(a_grants), .b_grants(b_grants)
`endif
    );

    // 74x157 with active-high enable: disabled output reads 0.
    assign y = mux_en ? (mux_s ? mux_b : mux_a) : 4'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-12s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        exp3 = '{4'h1, 4'h5, 4'h2, 4'h6, 4'h3, 4'h7, 4'h4, 4'h8};
        rst = 1'b1; a_in = '0; b_in = '0; a_valid = 0; b_valid = 0; y_ready = 0;

        // 1. reset and idle
        step(); step();
        chk("rst_en", 16'(mux_en), 16'd0);
        chk("rst_a_rdy", 16'(a_ready), 16'd0);
        chk("rst_mux_a", 16'(mux_a), 16'd0);
        rst = 1'b0;
        #1;
        chk("idle_a_rdy", 16'(a_ready), 16'd1);
        chk("idle_b_rdy", 16'(b_ready), 16'd1);
        step();
        chk("idle_en", 16'(mux_en), 16'd0);
        chk("idle_s", 16'(mux_s), 16'd0);

        // 2. single word on A, one-cycle latency then back to idle
        a_in = 4'hA; a_valid = 1; y_ready = 1;
        step();
        a_valid = 0;
        chk("t2_lat_en", 16'(mux_en), 16'd0);
        step();
        chk("t2_en", 16'(mux_en), 16'd1);
        chk("t2_s", 16'(mux_s), 16'd0);
        chk("t2_y", 16'(y), 16'hA);
        step();
        chk("t2_en_off", 16'(mux_en), 16'd0);

        // 3. both FIFOs full, alternating drain from a fresh reset
        rst = 1; y_ready = 0; step(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            a_in = 4'(i + 1); b_in = 4'(i + 5); a_valid = 1; b_valid = 1;
            step();
        end
        a_valid = 0; b_valid = 0;
        chk("t3_a_full", 16'(a_ready), 16'd0);
        chk("t3_b_full", 16'(b_ready), 16'd0);
        y_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_en", 16'(mux_en), 16'd1);
            chk("t3_y", 16'(y), 16'(exp3[i]));
            if (i == 1) begin
                chk("t3_a_rdy", 16'(a_ready), 16'd1);
                chk("t3_b_full2", 16'(b_ready), 16'd0);
            end
            step();
        end
        chk("t3_done_en", 16'(mux_en), 16'd0);
`ifdef JEFF_MUX_SCHEDULER_STATS_EN
        chk("a_grants", a_grants, 16'd4);
        chk("b_grants", b_grants, 16'd4);
`endif

        // 4. stall while serving B with head 7
        y_ready = 0;
        for (int i = 0; i < 3; i++) begin
            a_in = 4'(i + 1); b_in = 4'(i + 5); a_valid = 1; b_valid = 1;
            step();
        end
        a_valid = 0; b_valid = 0; y_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_y_pre", 16'(y), 16'(exp3[i]));
            step();
        end
        y_ready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_y", 16'(y), 16'h7);
            chk("t4_hold_s", 16'(mux_s), 16'd1);
            chk("t4_hold_en", 16'(mux_en), 16'd1);
            step();
        end
        y_ready = 1;
        step();
        chk("t4_end_en", 16'(mux_en), 16'd0);

        // 5. full FIFO refuses push on a pop edge
        y_ready = 0;
        for (int i = 0; i < 4; i++) begin
            a_in = 4'(i + 9); a_valid = 1;
            step();
        end
        chk("t5_full", 16'(a_ready), 16'd0);
        chk("t5_head", 16'(y), 16'h9);
        a_in = 4'hD; a_valid = 1; y_ready = 1;
        step();
        a_valid = 0;
        chk("t5_rdy", 16'(a_ready), 16'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_drain", 16'(y), 16'(10 + i));
            step();
        end
        chk("t5_empty_en", 16'(mux_en), 16'd0);

        // 5b. pointer wrap: ten words streamed through A
        for (int c = 0; c < 12; c++) begin
            a_valid = (c < 10);
            a_in = 4'(c + 3);
            step();
            if (c == 0 || c == 11) begin
                chk("wrap_en_off", 16'(mux_en), 16'd0);
            end else begin
                chk("wrap_en", 16'(mux_en), 16'd1);
                chk("wrap_y", 16'(y), 16'(c + 2));
            end
        end
        a_valid = 0;

        // 6. reset with words buffered
        y_ready = 0;
        a_in = 4'h3; b_in = 4'h4; a_valid = 1; b_valid = 1;
        step();
        b_valid = 0;
        step();
        a_valid = 0;
        rst = 1;
        step();
        chk("t6_en", 16'(mux_en), 16'd0);
        chk("t6_mux_a", 16'(mux_a), 16'd0);
        chk("t6_mux_b", 16'(mux_b), 16'd0);
        rst = 0;
        y_ready = 1;
        step(); step();
        chk("t6_still_idle", 16'(mux_en), 16'd0);
        chk("t6_a_rdy", 16'(a_ready), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
